// File: rtl/sw_debounce.sv
// Per-switch debouncer: two-flop synchronizer, per-bit counter/FSM, edge pulses,
// and a post-reset settle timer that gates the pulses until the outputs are trustworthy.
module sw_debounce #(
  parameter int NUM_SW    = 2,
  parameter int DB_CYCLES = 1000000
) (
  input  logic              CLK,
  input  logic              CPU_RESETN,
  input  logic [NUM_SW-1:0] SW,
  output logic [NUM_SW-1:0] SW_CLEAN,
  output logic [NUM_SW-1:0] SW_RISE,
  output logic [NUM_SW-1:0] SW_FALL,
  output logic              SW_VALID
);

  localparam int CW   = $clog2(DB_CYCLES + 1);
  localparam int STW  = $clog2(DB_CYCLES + 3);
  localparam logic [CW-1:0]  CNT_LAST    = CW'(DB_CYCLES - 1);
  localparam logic [STW-1:0] SETTLE_LAST = STW'(DB_CYCLES + 1);

  typedef enum logic {
    STABLE  = 1'b0,
    PENDING = 1'b1
  } db_state_t;

  logic [NUM_SW-1:0] sync1_reg;
  logic [NUM_SW-1:0] sync2_reg;
  logic [STW-1:0]    settle_reg;
  logic              valid_reg;

  always_ff @(posedge CLK or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= SW;
      sync2_reg <= sync1_reg;
    end
  end

  // Valid rises DB_CYCLES+2 edges after release: long enough for a level held
  // through reset to cross the synchronizer and be fully debounced.
  always_ff @(posedge CLK or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      settle_reg <= '0;
      valid_reg  <= 1'b0;
    end else if (!valid_reg) begin
      if (settle_reg == SETTLE_LAST) begin
        valid_reg <= 1'b1;
      end else begin
        settle_reg <= settle_reg + STW'(1);
      end
    end
  end

  assign SW_VALID = valid_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SW; gi++) begin : g_bit
      db_state_t     state_reg;
      logic [CW-1:0] cnt_reg;
      logic          clean_reg;
      logic          rise_reg;
      logic          fall_reg;

      always_ff @(posedge CLK or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
          state_reg <= STABLE;
          cnt_reg   <= '0;
          clean_reg <= 1'b0;
          rise_reg  <= 1'b0;
          fall_reg  <= 1'b0;
        end else begin
          rise_reg <= 1'b0;
          fall_reg <= 1'b0;
          case (state_reg)
            STABLE: begin
              if (sync2_reg[gi] != clean_reg) begin
                state_reg <= PENDING;
                cnt_reg   <= CW'(1);
              end else begin
                cnt_reg <= '0;
              end
            end
            PENDING: begin
              if (sync2_reg[gi] == clean_reg) begin
                state_reg <= STABLE;
                cnt_reg   <= '0;
              end else if (cnt_reg >= CNT_LAST) begin
                // Accept; >= keeps the counter from ever running past the limit.
                state_reg <= STABLE;
                cnt_reg   <= '0;
                clean_reg <= sync2_reg[gi];
                rise_reg  <= valid_reg & sync2_reg[gi];
                fall_reg  <= valid_reg & ~sync2_reg[gi];
              end else begin
                cnt_reg <= cnt_reg + CW'(1);
              end
            end
          endcase
        end
      end

      assign SW_CLEAN[gi] = clean_reg;
      assign SW_RISE[gi]  = rise_reg;
      assign SW_FALL[gi]  = fall_reg;
    end
  endgenerate

endmodule

// File: doc/sw_debounce.md
SW_DEBOUNCE -- requirements
Module: sw_debounce

Interface
REQ-001 The block SHALL have parameter NUM_SW, default 2, giving the number of switch inputs conditioned.
REQ-002 The block SHALL have parameter DB_CYCLES, default 1000000 (10 ms at 100 MHz), giving the stable-input cycle count required before acceptance; legal range 2 to 2^24.
REQ-003 The block SHALL have port CLK, input, 1 bit: the single clock; all state is on its rising edge.
REQ-004 The block SHALL have port CPU_RESETN, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port SW, input, NUM_SW bits: raw asynchronous switch levels.
REQ-006 The block SHALL have port SW_CLEAN, output, NUM_SW bits: debounced switch levels.
REQ-007 The block SHALL have port SW_RISE, output, NUM_SW bits: one-cycle pulse per bit on an accepted 0->1 change.
REQ-008 The block SHALL have port SW_FALL, output, NUM_SW bits: one-cycle pulse per bit on an accepted 1->0 change.
REQ-009 The block SHALL have port SW_VALID, output, 1 bit: high once SW_CLEAN reflects settled switch state after reset.

Function
REQ-010 Each SW bit SHALL pass through a two-flop synchronizer (sync1, sync2) before any other use; no other logic SHALL sample SW directly.
REQ-011 Each bit SHALL own an independent counter of width clog2(DB_CYCLES+1) and a two-state FSM: STABLE (sync2 == SW_CLEAN) and PENDING (sync2 != SW_CLEAN).
REQ-012 In STABLE the counter SHALL be 0; when sync2 differs from SW_CLEAN the FSM SHALL enter PENDING and the counter SHALL increment to 1 on that edge.
REQ-013 In PENDING, a cycle where sync2 equals SW_CLEAN (bounce) SHALL return the FSM to STABLE and clear the counter, with no SW_CLEAN change.
REQ-014 In PENDING, when the counter equals DB_CYCLES-1 and sync2 still differs, the next edge SHALL load SW_CLEAN from sync2, clear the counter and return to STABLE.
REQ-015 Latency: a clean SW step first sampled at edge N SHALL change SW_CLEAN at edge N+1+DB_CYCLES; any shorter pulse SHALL never reach SW_CLEAN.
REQ-016 SW_RISE/SW_FALL SHALL be registered and asserted in the same cycle SW_CLEAN changes, for exactly one cycle, and only when SW_VALID is 1.
REQ-017 The counter SHALL saturate and never wrap; no state SHALL be reachable with counter > DB_CYCLES-1.
REQ-018 Bits SHALL be fully independent; simultaneous acceptances on several bits SHALL produce simultaneous pulses on each.
REQ-019 A settle counter SHALL start at reset release; SW_VALID SHALL rise at edge DB_CYCLES+2 after release and stay high until reset.
REQ-020 While SW_VALID is 0, SW_CLEAN SHALL still debounce normally (e.g. a switch held high through reset is accepted) but no SW_RISE/SW_FALL SHALL be emitted.

Reset
REQ-021 Assertion of CPU_RESETN low SHALL immediately force sync1, sync2, SW_CLEAN, SW_RISE, SW_FALL, SW_VALID, all counters and the settle counter to 0 and all FSMs to STABLE, regardless of CLK.
REQ-022 Reset asserted mid-PENDING SHALL discard the partial count; after release, debouncing SHALL restart from a zero count.
REQ-023 Reset release SHALL be treated as synchronous to CLK by the integrator; the block SHALL not contain its own reset synchronizer.

Verification (DB_CYCLES=4, NUM_SW=2)
REQ-024 Reset, SW=00 held -> SW_VALID=1 at edge 6 after release, SW_CLEAN=00, no pulses.
REQ-025 After valid, SW[0] 0->1 step held -> SW_CLEAN[0]=1 at edge N+5, SW_RISE[0] one cycle wide at that edge, SW_FALL=00.
REQ-026 SW[1] toggles 1,0,1,0 with 3-cycle high periods then held high -> no change until the final stable run, then one SW_RISE[1], never an extra pulse.
REQ-027 SW=11 held through reset release -> SW_CLEAN=11 within DB_CYCLES+2 edges, SW_RISE and SW_FALL stay 00 throughout.
REQ-028 Both bits step 1->0 on the same edge -> SW_CLEAN=00 and SW_FALL=11 together for one cycle.
REQ-029 CPU_RESETN pulsed low after 3 PENDING cycles -> all outputs 0 asynchronously, SW_VALID low, full DB_CYCLES re-count after release before SW_CLEAN changes.
